i2s_capture_sequencer: RTL and testbench

I2S_CAPTURE_SEQUENCER -- requirements
Module: i2s_capture_sequencer

---
 rtl/i2s_pkg.sv | 17 +
 rtl/sync_fifo.sv | 44 ++++
 rtl/i2s_capture_sequencer.sv | 114 +++++++++++
 tb/tb_i2s_capture_sequencer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S capture sequencer: FSM encoding and
// controller reset hold length.
package i2s_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ARM     = 3'd1,
      ST_WARMUP  = 3'd2,
      ST_CAPTURE = 3'd3,
      ST_DRAIN   = 3'd4
   } state_t;

   // Cycles the controller is held in reset after a start is accepted.
   localparam int ARM_CYCLES = 4;
   localparam int ARM_CNT_W  = $clog2(ARM_CYCLES);

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; head entry is visible on rdata while not empty.
// Pointers carry one extra wrap bit to tell full from empty.
module sync_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 8
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             empty,
   output logic             full
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr, rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             do_push, do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop && !empty;
   // A full FIFO still takes a write when the head leaves in the same cycle.
   assign do_push = push && (!full || do_pop);
   assign rdata   = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
            wr_ptr              <= wr_ptr + 1'b1;
         end
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      end
   end

endmodule

// File: rtl/i2s_capture_sequencer.sv
// Sequences an I2S capture run: holds the controller in reset, drops warm-up
// frames, buffers captured frames in a show-ahead FIFO and drains on finish.
module i2s_capture_sequencer
   import i2s_pkg::*;
#(
   parameter int bits_per_word  = 32,
   parameter int fifo_depth     = 8,
   parameter int discard_frames = 2
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     start,
   input  logic                     stop,
   input  logic [15:0]              num_frames,
   output logic                     i2s_reset,
   input  logic                     frame_valid,
   input  logic [bits_per_word-1:0] frame_in_0,
   input  logic [bits_per_word-1:0] frame_in_1,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [bits_per_word-1:0] out_data_0,
   output logic [bits_per_word-1:0] out_data_1,
   output logic                     busy,
   output logic                     done,
   output logic                     overflow,
   output logic [15:0]              frames_seen
);

   localparam int DW = (discard_frames > 1) ? $clog2(discard_frames) : 1;

   state_t               state, state_nxt;
   logic [ARM_CNT_W-1:0] arm_cnt;
   logic [DW-1:0]        warm_cnt;
   logic [15:0]          nf_lat, seen_inc;
   logic                 push, pop, drop, count, fifo_empty, fifo_full;

   assign pop       = out_valid && out_ready;
   assign out_valid = !fifo_empty;
   assign busy      = (state != ST_IDLE);
   assign i2s_reset = (state == ST_IDLE) || (state == ST_ARM) || (state == ST_DRAIN);
   assign seen_inc  = (frames_seen == 16'hFFFF) ? frames_seen : frames_seen + 16'd1;

   always_comb begin
      state_nxt = state;
      done      = 1'b0;
      push      = 1'b0;
      drop      = 1'b0;
      count     = 1'b0;
      case (state)
         ST_IDLE:
            if (start) state_nxt = ST_ARM;
         ST_ARM:
            if (stop) state_nxt = ST_DRAIN;
            else if (arm_cnt == ARM_CNT_W'(ARM_CYCLES - 1))
               state_nxt = (discard_frames == 0) ? ST_CAPTURE : ST_WARMUP;
         ST_WARMUP:
            if (stop) state_nxt = ST_DRAIN;
            else if (frame_valid && (int'(warm_cnt) == discard_frames - 1))
               state_nxt = ST_CAPTURE;
         ST_CAPTURE:
            // A strobe coincident with stop is neither stored nor counted.
            if (stop) state_nxt = ST_DRAIN;
            else if (frame_valid) begin
               count = 1'b1;
               push  = !fifo_full || pop;
               drop  = fifo_full && !pop;
               if (nf_lat != 16'd0 && seen_inc == nf_lat) state_nxt = ST_DRAIN;
            end
         ST_DRAIN:
            if (fifo_empty) begin
               done      = 1'b1;
               state_nxt = ST_IDLE;
            end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state       <= ST_IDLE;
         arm_cnt     <= '0;
         warm_cnt    <= '0;
         nf_lat      <= '0;
         frames_seen <= '0;
         overflow    <= 1'b0;
      end else begin
         state    <= state_nxt;
         arm_cnt  <= (state == ST_ARM) ? arm_cnt + 1'b1 : '0;
         warm_cnt <= (state != ST_WARMUP) ? '0 : (frame_valid ? warm_cnt + 1'b1 : warm_cnt);
         if (state == ST_IDLE && start) begin
            nf_lat      <= num_frames;
            frames_seen <= '0;
            overflow    <= 1'b0;
         end
         if (count) frames_seen <= seen_inc;
         if (drop)  overflow    <= 1'b1;
      end
   end

   sync_fifo #(
      .WIDTH (2 * bits_per_word),
      .DEPTH (fifo_depth)
   ) u_fifo (
      .clock   (clock),
      .reset_n (reset_n),
      .push    (push),
      .wdata   ({frame_in_0, frame_in_1}),
      .pop     (pop),
      .rdata   ({out_data_0, out_data_1}),
      .empty   (fifo_empty),
      .full    (fifo_full)
   );

endmodule

// File: tb/tb_i2s_capture_sequencer.sv
// Directed bench for i2s_capture_sequencer with default parameters
// (32-bit words, depth 8, two warm-up frames).
module tb_i2s_capture_sequencer;

   logic        clock = 1'b0;
   logic        reset_n, start, stop, frame_valid, out_ready;
   logic [15:0] num_frames;
   logic [31:0] frame_in_0, frame_in_1;
   logic        i2s_reset, out_valid, busy, done, overflow;
   logic [31:0] out_data_0, out_data_1;
   logic [15:0] frames_seen;

   int          checks = 0, failures = 0, done_cnt = 0, d0;
   logic [63:0] rx[$];

   always #5 clock = ~clock;

   i2s_capture_sequencer dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .start       (start),
      .stop        (stop),
      .num_frames  (num_frames),
      .i2s_reset   (i2s_reset),
      .frame_valid (frame_valid),
      .frame_in_0  (frame_in_0),
      .frame_in_1  (frame_in_1),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data_0  (out_data_0),
      .out_data_1  (out_data_1),
      .busy        (busy),
      .done        (done),
      .overflow    (overflow),
      .frames_seen (frames_seen)
   );

   always @(posedge clock) begin
      if (done) done_cnt++;
      if (reset_n && out_valid && out_ready) rx.push_back({out_data_0, out_data_1});
   end

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
      end
   endtask

   function automatic logic [63:0] fw(input int id);
      return {32'hA000_0000 | 32'(id), 32'hB000_0000 | 32'(id)};
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic send(input int id, input logic with_stop = 1'b0);
      frame_valid = 1'b1;
      frame_in_0  = 32'hA000_0000 | 32'(id);
      frame_in_1  = 32'hB000_0000 | 32'(id);
      stop        = with_stop;
      tick();
      frame_valid = 1'b0;
      stop        = 1'b0;
   endtask

   task automatic do_start(input logic [15:0] nf);
      start      = 1'b1;
      num_frames = nf;
      tick();
      start = 1'b0;
   endtask

   // Start, ride out the 4-cycle controller reset and the two warm-up frames.
   task automatic start_run(input logic [15:0] nf, input int warm_id);
      do_start(nf);
      repeat (3) tick();
      tick();
      send(warm_id);
      send(warm_id + 1);
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (busy && n < 100) begin
         tick();
         n++;
      end
      chk(tag, {63'd0, busy}, 64'd0);
   endtask

   initial begin
      reset_n = 1'b0; start = 1'b0; stop = 1'b0; frame_valid = 1'b0;
      out_ready = 1'b0; num_frames = '0; frame_in_0 = '0; frame_in_1 = '0;
      #3;
      chk("rst_i2s_reset", {63'd0, i2s_reset}, 64'd1);
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_busy",      {63'd0, busy}, 64'd0);
      chk("rst_done",      {63'd0, done}, 64'd0);
      chk("rst_overflow",  {63'd0, overflow}, 64'd0);
      chk("rst_seen",      {48'd0, frames_seen}, 64'd0);
      chk("rst_data",      {out_data_0, out_data_1}, 64'd0);
      repeat (2) @(posedge clock);
      #1 reset_n = 1'b1;
      tick();

      // Basic run: 2 warm-up drops, 3 captured frames in order, then done.
      out_ready = 1'b1;
      rx.delete();
      d0 = done_cnt;
      do_start(16'd3);
      chk("t1_arm_busy", {63'd0, busy}, 64'd1);
      chk("t1_arm_rst0", {63'd0, i2s_reset}, 64'd1);
      repeat (3) tick();
      chk("t1_arm_rst3", {63'd0, i2s_reset}, 64'd1);
      tick();
      chk("t1_warm_rst", {63'd0, i2s_reset}, 64'd0);
      for (int i = 0; i < 5; i++) send(i);
      wait_idle("t1_idle");
      chk("t1_cnt",  64'(rx.size()), 64'd3);
      for (int i = 0; i < 3 && i < rx.size(); i++) chk("t1_data", rx[i], fw(i + 2));
      chk("t1_done", 64'(done_cnt - d0), 64'd1);
      chk("t1_ovf",  {63'd0, overflow}, 64'd0);
      chk("t1_seen", {48'd0, frames_seen}, 64'd3);

      // Backpressure: 8 buffered, 2 dropped, then drain.
      out_ready = 1'b0;
      rx.delete();
      d0 = done_cnt;
      start_run(16'd10, 100);
      for (int i = 0; i < 10; i++) send(102 + i);
      chk("t2_ovf",   {63'd0, overflow}, 64'd1);
      chk("t2_seen",  {48'd0, frames_seen}, 64'd10);
      chk("t2_busy",  {63'd0, busy}, 64'd1);
      chk("t2_ovld",  {63'd0, out_valid}, 64'd1);
      chk("t2_nodone", 64'(done_cnt - d0), 64'd0);
      out_ready = 1'b1;
      wait_idle("t2_idle");
      chk("t2_cnt",   64'(rx.size()), 64'd8);
      for (int i = 0; i < 8 && i < rx.size(); i++) chk("t2_data", rx[i], fw(102 + i));
      chk("t2_done",  64'(done_cnt - d0), 64'd1);

      // Full FIFO with simultaneous push and pop: frame accepted, no overflow.
      out_ready = 1'b0;
      rx.delete();
      d0 = done_cnt;
      start_run(16'd0, 198);
      chk("t3_ovf_clr", {63'd0, overflow}, 64'd0);
      for (int i = 0; i < 8; i++) send(200 + i);
      out_ready = 1'b1;
      send(208);
      out_ready = 1'b0;
      chk("t3_ovf_pp", {63'd0, overflow}, 64'd0);
      chk("t3_seen",   {48'd0, frames_seen}, 64'd9);
      send(209);
      chk("t3_ovf_full", {63'd0, overflow}, 64'd1);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      out_ready = 1'b1;
      wait_idle("t3_idle");
      chk("t3_cnt",  64'(rx.size()), 64'd9);
      for (int i = 0; i < 9 && i < rx.size(); i++) chk("t3_data", rx[i], fw(200 + i));
      chk("t3_done", 64'(done_cnt - d0), 64'd1);

      // Continuous mode ended by stop; frame coincident with stop is dropped.
      out_ready = 1'b1;
      rx.delete();
      d0 = done_cnt;
      start_run(16'd0, 300);
      for (int i = 0; i < 20; i++) send(302 + i);
      chk("t4_busy", {63'd0, busy}, 64'd1);
      send(322, 1'b1);
      chk("t4_seen", {48'd0, frames_seen}, 64'd20);
      wait_idle("t4_idle");
      chk("t4_cnt",  64'(rx.size()), 64'd20);
      if (rx.size() > 0) chk("t4_last", rx[rx.size() - 1], fw(321));
      chk("t4_done", 64'(done_cnt - d0), 64'd1);
      chk("t4_ovf",  {63'd0, overflow}, 64'd0);

      // Stop in IDLE ignored; start during ARM ignored.
      stop = 1'b1;
      tick();
      stop = 1'b0;
      chk("t5_idle_busy", {63'd0, busy}, 64'd0);
      chk("t5_idle_seen", {48'd0, frames_seen}, 64'd20);
      rx.delete();
      d0 = done_cnt;
      do_start(16'd2);
      start = 1'b1;
      num_frames = 16'd7;
      tick();
      start = 1'b0;
      repeat (2) tick();
      chk("t5_arm_rst", {63'd0, i2s_reset}, 64'd1);
      tick();
      chk("t5_warm_rst", {63'd0, i2s_reset}, 64'd0);
      for (int i = 0; i < 4; i++) send(400 + i);
      wait_idle("t5_idle");
      chk("t5_seen", {48'd0, frames_seen}, 64'd2);
      chk("t5_done", 64'(done_cnt - d0), 64'd1);

      // Reset mid-capture with 3 frames buffered.
      out_ready = 1'b0;
      d0 = done_cnt;
      start_run(16'd0, 500);
      for (int i = 0; i < 3; i++) send(502 + i);
      chk("t6_ovld_pre", {63'd0, out_valid}, 64'd1);
      #2 reset_n = 1'b0;
      #1;
      chk("t6_ovld",  {63'd0, out_valid}, 64'd0);
      chk("t6_i2srst", {63'd0, i2s_reset}, 64'd1);
      chk("t6_busy",  {63'd0, busy}, 64'd0);
      chk("t6_data",  {out_data_0, out_data_1}, 64'd0);
      repeat (3) @(posedge clock);
      #1 reset_n = 1'b1;
      out_ready = 1'b1;
      repeat (3) tick();
      chk("t6_ovld_post", {63'd0, out_valid}, 64'd0);
      chk("t6_nodone", 64'(done_cnt - d0), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
